// File: rtl/adc_timing.sv
// Conversion-start and serial-clock framing for a 12-bit SPI ADC.
// Each frame: CONVST pulse, conversion wait, 12 SCLK pulses, idle gap.
module adc_timing #(
    parameter int CLK_DIV   = 2,
    parameter int CONV_HIGH = 2,
    parameter int CONV_WAIT = 80,
    parameter int GAP       = 2
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic ENABLE,
    output logic ADC_CONVST,
    output logic SCLK,
    output logic BUSY,
    output logic FRAME_DONE
);

    // state   | meaning
    // S_IDLE  | all outputs low, waiting for ENABLE
    // S_CONV  | ADC_CONVST high for CONV_HIGH cycles
    // S_WAIT  | conversion time, CONV_WAIT cycles
    // S_SHIFT | 24 half-periods of CLK_DIV cycles, SCLK low first
    // S_GAP   | GAP idle cycles, FRAME_DONE on the first one

    localparam int MAX_A  = (CONV_WAIT > GAP) ? CONV_WAIT : GAP;
    localparam int MAX_B  = (MAX_A > CLK_DIV) ? MAX_A : CLK_DIV;
    localparam int MAX_C  = (MAX_B > CONV_HIGH) ? MAX_B : CONV_HIGH;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] TC_CONV = CNT_W'(CONV_HIGH - 1);
    localparam logic [CNT_W-1:0] TC_WAIT = CNT_W'(CONV_WAIT - 1);
    localparam logic [CNT_W-1:0] TC_HALF = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] TC_GAP  = CNT_W'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_WAIT,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       bit_cnt, bit_cnt_nxt;
    logic             sclk_nxt;
    logic             half_end;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        bit_cnt_nxt = bit_cnt;
        sclk_nxt    = SCLK;
        half_end    = (cnt == TC_HALF);

        case (state)
            S_IDLE:  if (ENABLE) state_nxt = S_CONV;
            S_CONV:  if (cnt == TC_CONV) state_nxt = S_WAIT;
            S_WAIT:  if (cnt == TC_WAIT) state_nxt = S_SHIFT;
            // leave on the 12th high-to-low transition; SCLK doubles as the phase bit
            S_SHIFT: if (half_end && SCLK && bit_cnt == 4'd11) state_nxt = S_GAP;
            S_GAP:   if (cnt == TC_GAP) state_nxt = ENABLE ? S_CONV : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (state_nxt != state || state == S_IDLE) begin
            cnt_nxt     = '0;
            bit_cnt_nxt = '0;
            sclk_nxt    = 1'b0;
        end else if (state == S_SHIFT && half_end) begin
            cnt_nxt  = '0;
            sclk_nxt = ~SCLK;
            if (SCLK) bit_cnt_nxt = bit_cnt + 4'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            ADC_CONVST <= 1'b0;
            SCLK       <= 1'b0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            SCLK       <= sclk_nxt;
            ADC_CONVST <= (state_nxt == S_CONV);
            BUSY       <= (state_nxt != S_IDLE);
            FRAME_DONE <= (state == S_SHIFT) && (state_nxt == S_GAP);
        end
    end

endmodule

// File: tb/tb_adc_timing.sv
// Bench for adc_timing: a frame-position reference model checks both a default
// instance and a minimum-timing instance every cycle, plus directed sequences.
module tb_adc_timing;

    localparam int CH0 = 2, CW0 = 80, CD0 = 2, GP0 = 2;
    localparam int L0  = CH0 + CW0 + 24 * CD0 + GP0;
    localparam int CH1 = 2, CW1 = 1, CD1 = 1, GP1 = 1;
    localparam int L1  = CH1 + CW1 + 24 * CD1 + GP1;

    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b0;
    logic en0 = 1'b0, en1 = 1'b0;
    logic conv0, sclk0, busy0, done0;
    logic conv1, sclk1, busy1, done1;

    adc_timing u_dut0 (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .ENABLE     (en0),
        .ADC_CONVST (conv0),
        .SCLK       (sclk0),
        .BUSY       (busy0),
        .FRAME_DONE (done0)
    );

    adc_timing #(
        .CLK_DIV   (CD1),
        .CONV_HIGH (CH1),
        .CONV_WAIT (CW1),
        .GAP       (GP1)
    ) u_dut1 (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .ENABLE     (en1),
        .ADC_CONVST (conv1),
        .SCLK       (sclk1),
        .BUSY       (busy1),
        .FRAME_DONE (done1)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pos [2];
    logic [3:0] prev [2];
    int conv_rises [2], sclk_rises [2], dones [2], overlap [2];
    int first_conv [2], last_conv [2], first_sclk [2], last_sclk [2], last_done [2];

    typedef struct {
        int         at;
        logic [3:0] exp;   // {convst, sclk, busy, done}
    } vec_t;
    vec_t tbl [12];

    // Expected outputs at frame position p (p < 0 means idle).
    function automatic logic [3:0] ref_out(input int p, input int ch, input int cw, input int cd);
        logic [3:0] r;
        int s0;
        r  = '0;
        s0 = ch + cw;
        if (p >= 0) begin
            r[1] = 1'b1;
            r[3] = (p < ch);
            if (p >= s0 && p < s0 + 24 * cd) r[2] = (((p - s0) / cd) % 2) == 1;
            r[0] = (p == s0 + 24 * cd);
        end
        return r;
    endfunction

    function automatic int ref_next(input int p, input logic en, input int len);
        if (p < 0 || p == len - 1) return en ? 0 : -1;
        return p + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic observe(input int d, input logic [3:0] o, input logic [3:0] e);
        chk(d == 0 ? "ref_dut0" : "ref_dut1", {28'd0, o}, {28'd0, e});
        if (o[3] && !prev[d][3]) begin
            conv_rises[d]++;
            if (first_conv[d] < 0) first_conv[d] = cyc;
            last_conv[d] = cyc;
        end
        if (o[2] && !prev[d][2]) begin
            sclk_rises[d]++;
            if (first_sclk[d] < 0) first_sclk[d] = cyc;
            last_sclk[d] = cyc;
        end
        if (o[0]) begin
            dones[d]++;
            last_done[d] = cyc;
        end
        if (o[3] && o[2]) overlap[d]++;
        prev[d] = o;
    endtask

    task automatic step(input logic e0, input logic e1);
        en0 = e0;
        en1 = e1;
        @(posedge CLOCK_50);
        cyc++;
        if (!RESET) begin
            pos[0] = ref_next(pos[0], e0, L0);
            pos[1] = ref_next(pos[1], e1, L1);
        end
        #1;
        observe(0, {conv0, sclk0, busy0, done0}, ref_out(pos[0], CH0, CW0, CD0));
        observe(1, {conv1, sclk1, busy1, done1}, ref_out(pos[1], CH1, CW1, CD1));
    endtask

    task automatic clr_trk();
        for (int d = 0; d < 2; d++) begin
            conv_rises[d] = 0; sclk_rises[d] = 0; dones[d] = 0; overlap[d] = 0;
            first_conv[d] = -1; last_conv[d] = -1;
            first_sclk[d] = -1; last_sclk[d] = -1; last_done[d] = -1;
        end
    endtask

    // Assert reset away from the clock edge and confirm outputs clear without an edge.
    task automatic apply_reset(input int hold);
        RESET = 1'b1;
        #1;
        chk("async_reset_dut0", {28'd0, conv0, sclk0, busy0, done0}, 32'd0);
        chk("async_reset_dut1", {28'd0, conv1, sclk1, busy1, done1}, 32'd0);
        pos[0] = -1;
        pos[1] = -1;
        prev[0] = '0;
        prev[1] = '0;
        for (int i = 0; i < hold; i++) step(en0, en1);
        RESET = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int p;

        tbl[0]  = '{0,   4'b1010};
        tbl[1]  = '{1,   4'b1010};
        tbl[2]  = '{2,   4'b0010};
        tbl[3]  = '{83,  4'b0010};
        tbl[4]  = '{84,  4'b0110};
        tbl[5]  = '{85,  4'b0110};
        tbl[6]  = '{86,  4'b0010};
        tbl[7]  = '{129, 4'b0110};
        tbl[8]  = '{130, 4'b0011};
        tbl[9]  = '{131, 4'b0010};
        tbl[10] = '{132, 4'b0000};
        tbl[11] = '{140, 4'b0000};

        pos[0] = -1; pos[1] = -1;
        prev[0] = '0; prev[1] = '0;
        clr_trk();

        // reset held with ENABLE high, first frame timing
        en0 = 1'b1; en1 = 1'b1;
        #2;
        apply_reset(3);
        step(1, 1);
        chk("convst_first_edge", {31'd0, conv0}, 32'd1);
        step(1, 1);
        chk("convst_still_high", {31'd0, conv0}, 32'd1);
        step(0, 1);
        chk("convst_low_after_2", {31'd0, conv0}, 32'd0);
        k = 2;
        while (!sclk0 && k < 200) begin
            step(0, 1);
            k++;
        end
        chk("first_sclk_after_convst", k, 84);
        k = 0;
        while (busy0 && k < 300) begin
            step(0, 1);
            k++;
        end
        chk("first_frame_drain", {31'd0, busy0}, 32'd0);
        chk("first_frame_single_convst", conv_rises[0], 1);

        // single frame from a one-cycle ENABLE pulse, table driven
        clr_trk();
        step(1, 1);
        p = 0;
        for (int i = 0; i < 12; i++) begin
            while (p < tbl[i].at) begin
                step(0, 1);
                p++;
            end
            chk($sformatf("tbl_%0d_at_%0d", i, tbl[i].at), {28'd0, conv0, sclk0, busy0, done0},
                {28'd0, tbl[i].exp});
        end
        chk("single_sclk_rises", sclk_rises[0], 12);
        chk("single_sclk_span", last_sclk[0] - first_sclk[0], 44);
        chk("single_done_count", dones[0], 1);
        chk("single_done_offset", last_done[0] - first_conv[0], 130);
        chk("single_convst_count", conv_rises[0], 1);

        // ten back-to-back frames
        clr_trk();
        for (int i = 0; i < 10 * L0; i++) step(1, 1);
        step(0, 1);
        chk("cont_convst_count", conv_rises[0], 10);
        chk("cont_convst_span", last_conv[0] - first_conv[0], 9 * 132);
        chk("cont_sclk_rises", sclk_rises[0], 120);
        chk("cont_done_count", dones[0], 10);
        chk("cont_idle_after", {31'd0, busy0}, 32'd0);

        // ENABLE dropped during SHIFT
        clr_trk();
        step(1, 1);
        for (int i = 0; i < 101; i++) step(1, 1);
        k = 0;
        while (busy0 && k < 300) begin
            step(0, 1);
            k++;
        end
        chk("drop_idle", {31'd0, busy0}, 32'd0);
        chk("drop_sclk_rises", sclk_rises[0], 12);
        chk("drop_done_count", dones[0], 1);
        chk("drop_convst_count", conv_rises[0], 1);

        // reset mid-SHIFT while SCLK is high
        clr_trk();
        step(1, 1);
        for (int i = 0; i < 89; i++) step(1, 1);
        chk("sclk_high_before_reset", {31'd0, sclk0}, 32'd1);
        apply_reset(2);
        chk("no_done_on_reset", dones[0], 0);
        clr_trk();
        step(1, 1);
        k = 0;
        while (!done0 && k < 300) begin
            step(1, 1);
            k++;
        end
        chk("frame_after_reset_done_at", k, 130);
        k = 0;
        while (busy0 && k < 300) begin
            step(0, 1);
            k++;
        end
        chk("frame_after_reset_drain", {31'd0, busy0}, 32'd0);

        // randomized enables and occasional resets against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) apply_reset(int'($urandom_range(0, 2)));
            else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // minimum-timing instance: 28-cycle frames
        en0 = 1'b0; en1 = 1'b0;
        apply_reset(1);
        clr_trk();
        for (int i = 0; i < 5 * L1; i++) step(0, 1);
        step(0, 0);
        chk("fast_convst_count", conv_rises[1], 5);
        chk("fast_convst_span", last_conv[1] - first_conv[1], 4 * 28);
        chk("fast_first_sclk", first_sclk[1] - first_conv[1], 4);
        chk("fast_sclk_rises", sclk_rises[1], 60);
        chk("fast_done_count", dones[1], 5);
        chk("fast_overlap", overlap[1], 0);
        chk("fast_idle_after", {31'd0, busy1}, 32'd0);
        chk("dut0_overlap", overlap[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
